// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: tagged memory request/response port to AXI4-Lite master.
// Requests queue in a request FIFO and issue on AR or AW+W in order.
// An order FIFO records {is_wr, tag} for every accepted request so that B and R
// responses are returned to the requester strictly in request order.
// Optional build macro MEM_AXI_BRIDGE_ERR_EN: when defined, mem_error_o reports a
// non-OKAY bresp/rresp on the acknowledged response; otherwise it is tied low.
module mem_axi_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 11,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // Memory request port
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_data_wr_i,
  input  logic                  mem_rd_i,
  input  logic [DATA_W/8-1:0]   mem_wr_i,
  input  logic [TAG_W-1:0]      mem_req_tag_i,
  input  logic                  mem_resp_accept_i,
  output logic                  mem_accept_o,
  output logic                  mem_ack_o,
  output logic [DATA_W-1:0]     mem_data_rd_o,
  output logic [TAG_W-1:0]      mem_resp_tag_o,
  output logic                  mem_error_o,
  // AXI4-Lite write address channel
  output logic                  axi_awvalid_o,
  input  logic                  axi_awready_i,
  output logic [ADDR_W-1:0]     axi_awaddr_o,
  // AXI4-Lite write data channel
  output logic                  axi_wvalid_o,
  input  logic                  axi_wready_i,
  output logic [DATA_W-1:0]     axi_wdata_o,
  output logic [DATA_W/8-1:0]   axi_wstrb_o,
  // AXI4-Lite write response channel
  input  logic                  axi_bvalid_i,
  output logic                  axi_bready_o,
  input  logic [1:0]            axi_bresp_i,
  // AXI4-Lite read address channel
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  output logic [ADDR_W-1:0]     axi_araddr_o,
  // AXI4-Lite read data channel
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o,
  input  logic [DATA_W-1:0]     axi_rdata_i,
  input  logic [1:0]            axi_rresp_i
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [CntW-1:0]   FullCnt  = CntW'(DEPTH);
  // Clears the byte-offset bits so every AXI address is bus-word aligned.
  localparam logic [ADDR_W-1:0] AddrMask = ~ADDR_W'(StrbW - 1);

  typedef struct packed {
    logic              is_rd;
    logic [StrbW-1:0]  strb;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } req_t;

  typedef struct packed {
    logic             is_wr;
    logic [TAG_W-1:0] tag;
  } ord_t;

  // Request FIFO state
  req_t            req_mem_q [DEPTH];
  logic [PtrW-1:0] req_wr_ptr_q, req_wr_ptr_d;
  logic [PtrW-1:0] req_rd_ptr_q, req_rd_ptr_d;
  logic [CntW-1:0] req_cnt_q, req_cnt_d;

  // Order FIFO state
  ord_t            ord_mem_q [DEPTH];
  logic [PtrW-1:0] ord_wr_ptr_q, ord_wr_ptr_d;
  logic [PtrW-1:0] ord_rd_ptr_q, ord_rd_ptr_d;
  logic [CntW-1:0] ord_cnt_q, ord_cnt_d;

  // Per-channel completion flags for the write at the request FIFO head
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  logic req_any;
  logic push;
  req_t req_wdata;
  ord_t ord_wdata;
  req_t req_head;
  ord_t ord_head;
  logic req_valid;
  logic ord_valid;
  logic head_is_wr;
  logic ar_hs;
  logic aw_hs;
  logic w_hs;
  logic req_pop;
  logic ord_pop;

  // ---------------------------------------------------------------------------
  // Request acceptance
  // ---------------------------------------------------------------------------

  // Registered counts only: a pop in this cycle does not open a slot until the next.
  assign mem_accept_o = (req_cnt_q != FullCnt) && (ord_cnt_q != FullCnt);
  assign req_any      = mem_rd_i | (|mem_wr_i);
  assign push         = req_any & mem_accept_o;

  // A read strobe wins when both read and write are requested together.
  assign req_wdata.is_rd = mem_rd_i;
  assign req_wdata.strb  = mem_wr_i;
  assign req_wdata.data  = mem_data_wr_i;
  assign req_wdata.addr  = mem_addr_i;

  assign ord_wdata.is_wr = ~mem_rd_i;
  assign ord_wdata.tag   = mem_req_tag_i;

  // FIFO storage: contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      req_mem_q[req_wr_ptr_q] <= req_wdata;
      ord_mem_q[ord_wr_ptr_q] <= ord_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // AXI request issue from the request FIFO head
  // ---------------------------------------------------------------------------

  assign req_head  = req_mem_q[req_rd_ptr_q];
  assign req_valid = (req_cnt_q != '0);

  assign axi_arvalid_o = req_valid & req_head.is_rd;
  assign axi_awvalid_o = req_valid & ~req_head.is_rd & ~aw_done_q;
  assign axi_wvalid_o  = req_valid & ~req_head.is_rd & ~w_done_q;

  assign axi_araddr_o  = req_head.addr & AddrMask;
  assign axi_awaddr_o  = req_head.addr & AddrMask;
  assign axi_wdata_o   = req_head.data;
  assign axi_wstrb_o   = req_head.strb;

  assign ar_hs = axi_arvalid_o & axi_arready_i;
  assign aw_hs = axi_awvalid_o & axi_awready_i;
  assign w_hs  = axi_wvalid_o & axi_wready_i;

  // A write retires once both AW and W have handshaken, in whichever cycles.
  assign req_pop = ar_hs | (req_valid & ~req_head.is_rd &
                            (aw_done_q | aw_hs) & (w_done_q | w_hs));

  // Track which write channel has already completed for the current head.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (req_pop) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_done_d = 1'b1;
      end
      if (w_hs) begin
        w_done_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response return in request order
  // ---------------------------------------------------------------------------

  assign ord_head   = ord_mem_q[ord_rd_ptr_q];
  assign ord_valid  = (ord_cnt_q != '0);
  assign head_is_wr = ord_head.is_wr;

  // Only the channel the order head expects is ever readied; the other stalls.
  assign axi_bready_o = mem_resp_accept_i & ord_valid & head_is_wr;
  assign axi_rready_o = mem_resp_accept_i & ord_valid & ~head_is_wr;

  assign mem_ack_o      = ord_valid & (head_is_wr ? axi_bvalid_i : axi_rvalid_i);
  assign mem_resp_tag_o = ord_head.tag;
  assign mem_data_rd_o  = axi_rdata_i;
  assign ord_pop        = mem_ack_o & mem_resp_accept_i;

`ifdef MEM_AXI_BRIDGE_ERR_EN
  assign mem_error_o = mem_ack_o &
                       (head_is_wr ? (axi_bresp_i != 2'b00) : (axi_rresp_i != 2'b00));
`else
  logic unused_resp;
  assign unused_resp = ^{axi_bresp_i, axi_rresp_i};
  assign mem_error_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO pointer and occupancy bookkeeping
  // ---------------------------------------------------------------------------

  // Advance pointers and occupancy of both FIFOs.
  always_comb begin
    req_wr_ptr_d = req_wr_ptr_q;
    req_rd_ptr_d = req_rd_ptr_q;
    ord_wr_ptr_d = ord_wr_ptr_q;
    ord_rd_ptr_d = ord_rd_ptr_q;
    if (push) begin
      req_wr_ptr_d = req_wr_ptr_q + PtrW'(1);
      ord_wr_ptr_d = ord_wr_ptr_q + PtrW'(1);
    end
    if (req_pop) begin
      req_rd_ptr_d = req_rd_ptr_q + PtrW'(1);
    end
    if (ord_pop) begin
      ord_rd_ptr_d = ord_rd_ptr_q + PtrW'(1);
    end
    req_cnt_d = req_cnt_q + CntW'(push) - CntW'(req_pop);
    ord_cnt_d = ord_cnt_q + CntW'(push) - CntW'(ord_pop);
  end

  // Control state; reset discards every queued request immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_wr_ptr_q <= '0;
      req_rd_ptr_q <= '0;
      req_cnt_q    <= '0;
      ord_wr_ptr_q <= '0;
      ord_rd_ptr_q <= '0;
      ord_cnt_q    <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      req_wr_ptr_q <= req_wr_ptr_d;
      req_rd_ptr_q <= req_rd_ptr_d;
      req_cnt_q    <= req_cnt_d;
      ord_wr_ptr_q <= ord_wr_ptr_d;
      ord_rd_ptr_q <= ord_rd_ptr_d;
      ord_cnt_q    <= ord_cnt_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule
